// File: rtl/packet_fifo_pkg.sv
// Shared helpers for the single-clock packet FIFO:
// wrapping pointer difference and DEPTH legality check.
package packet_fifo_pkg;

  localparam int PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_wide_t;

  // Difference of two pointers that wrap modulo 2^(abits+1).
  function automatic ptr_wide_t ptr_diff(
    input ptr_wide_t a,
    input ptr_wide_t b,
    input int        abits
  );
    ptr_wide_t mask;
    mask = (ptr_wide_t'(1) << (abits + 1)) - ptr_wide_t'(1);
    return (a - b) & mask;
  endfunction

  // DEPTH must be a power of two and at least 4.
  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/MemoryMacro.sv
// Simple dual-port memory: port A writes, port B reads
// (1 cycle, +1 with OUT_REG). Output registers reset to 0.
module MemoryMacro #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int DUAL_PORT = 1,
  parameter int TRUE_DUAL = 0,
  parameter int USE_BLOCK = 1,
  parameter int OUT_REG   = 1
) (
  input  logic                 clk_a,
  input  logic                 we_a,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [WIDTH-1:0]     din_a,
  input  logic                 clk_b,
  input  logic                 rst_b,
  input  logic                 en_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  output logic [WIDTH-1:0]     dout_b
);

  if (DUAL_PORT != 1 || TRUE_DUAL != 0) begin : g_cfg
    $error("MemoryMacro: only simple dual-port is built");
  end

  logic [WIDTH-1:0] q;

  if (USE_BLOCK != 0) begin : g_block
    (* ram_style = "block" *)
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_a) begin
      if (we_a) mem[addr_a] <= din_a;
    end

    always_ff @(posedge clk_b) begin
      if (rst_b)     q <= '0;
      else if (en_b) q <= mem[addr_b];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd;

    always_ff @(posedge clk_a) begin
      if (we_a) mem[addr_a] <= din_a;
    end

    assign rd = mem[addr_b];

    always_ff @(posedge clk_b) begin
      if (rst_b)     q <= '0;
      else if (en_b) q <= rd;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] q2;

    always_ff @(posedge clk_b) begin
      if (rst_b) q2 <= '0;
      else       q2 <= q;
    end

    assign dout_b = q2;
  end else begin : g_noreg
    assign dout_b = q;
  end

endmodule

// File: rtl/single_clock_packet_fifo.sv
// Packet FIFO: words become readable only after wr_commit;
// wr_rollback drops the open frame. Define
// PACKET_FIFO_RD_ROLLBACK_EN for rd_commit/rd_rollback
// (re-read of popped words); otherwise pops free space.
// Ports: clk, reset (sync, high); wr_en/wr_data/wr_commit/
// wr_rollback -> wr_size/wr_full/wr_overflow; rd_en/
// rd_commit/rd_rollback -> rd_data/rd_valid/rd_size/
// rd_empty/rd_underflow.
module single_clock_packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int USE_BLOCK = 1,
  parameter int OUT_REG   = 1,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_commit,
  input  logic                 wr_rollback,
  output logic [ADDR_BITS:0]   wr_size,
  output logic                 wr_full,
  output logic                 wr_overflow,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS:0]   rd_size,
  output logic                 rd_empty,
  output logic                 rd_underflow,
  input  logic                 rd_commit,
  input  logic                 rd_rollback
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 4");
  end

  typedef logic [ADDR_BITS:0] ptr_t;

  localparam ptr_t ONE = ptr_t'(1);
  localparam ptr_t CAP = ptr_t'(DEPTH);

  ptr_t wr_ptr, wr_cptr, rd_ptr, rd_cptr;
  ptr_t wr_ptr_n, wr_cptr_n, rd_ptr_n;
  logic wr_acc, rd_acc;

  assign wr_acc = wr_en && !wr_full && !wr_rollback;

  always_comb begin
    wr_ptr_n  = wr_ptr;
    wr_cptr_n = wr_cptr;
    if (wr_rollback) begin
      wr_ptr_n = wr_cptr;
    end else begin
      if (wr_acc)    wr_ptr_n  = wr_ptr + ONE;
      if (wr_commit) wr_cptr_n = wr_ptr_n;
    end
  end

`ifdef PACKET_FIFO_RD_ROLLBACK_EN
  ptr_t rd_cptr_n;

  assign rd_acc = rd_en && !rd_empty && !rd_rollback;

  always_comb begin
    rd_ptr_n  = rd_ptr;
    rd_cptr_n = rd_cptr;
    if (rd_rollback) begin
      rd_ptr_n = rd_cptr;
    end else begin
      if (rd_acc)    rd_ptr_n  = rd_ptr + ONE;
      if (rd_commit) rd_cptr_n = rd_ptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_cptr <= '0;
    else       rd_cptr <= rd_cptr_n;
  end
`else
  logic unused_rd_ctl;

  assign unused_rd_ctl = rd_commit ^ rd_rollback;
  assign rd_acc        = rd_en && !rd_empty;
  assign rd_ptr_n      = rd_acc ? rd_ptr + ONE : rd_ptr;
  assign rd_cptr       = rd_ptr;
`endif

  // Consumption (writes, pops) is seen at once so the
  // accept gates stay exact; commits and freed space
  // show up one cycle later.
  ptr_wide_t used_w, avail_w;
  ptr_t      used, avail;
  logic      unused_hi;

  assign used_w  = ptr_diff(ptr_wide_t'(wr_ptr_n),
                            ptr_wide_t'(rd_cptr), ADDR_BITS);
  assign avail_w = ptr_diff(ptr_wide_t'(wr_cptr),
                            ptr_wide_t'(rd_ptr_n), ADDR_BITS);
  assign used    = used_w[ADDR_BITS:0];
  assign avail   = avail_w[ADDR_BITS:0];
  assign unused_hi = ^{used_w[PTR_MAX-1:ADDR_BITS+1],
                       avail_w[PTR_MAX-1:ADDR_BITS+1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      wr_cptr      <= '0;
      rd_ptr       <= '0;
      wr_size      <= CAP;
      wr_full      <= 1'b0;
      rd_size      <= '0;
      rd_empty     <= 1'b1;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      wr_cptr      <= wr_cptr_n;
      rd_ptr       <= rd_ptr_n;
      wr_size      <= CAP - used;
      wr_full      <= (used == CAP);
      rd_size      <= avail;
      rd_empty     <= (avail == '0);
      wr_overflow  <= wr_en && wr_full;
      rd_underflow <= rd_en && rd_empty;
    end
  end

  logic [OUT_REG:0] vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= rd_acc;
      for (int i = 1; i <= OUT_REG; i++) vld[i] <= vld[i-1];
    end
  end

  assign rd_valid = vld[OUT_REG];

  MemoryMacro #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS),
    .DUAL_PORT(1),
    .TRUE_DUAL(0),
    .USE_BLOCK(USE_BLOCK),
    .OUT_REG  (OUT_REG)
  ) u_mem (
    .clk_a (clk),
    .we_a  (wr_acc),
    .addr_a(wr_ptr[ADDR_BITS-1:0]),
    .din_a (wr_data),
    .clk_b (clk),
    .rst_b (reset),
    .en_b  (rd_acc),
    .addr_b(rd_ptr[ADDR_BITS-1:0]),
    .dout_b(rd_data)
  );

endmodule

// File: tb/tb_single_clock_packet_fifo.sv
// Scoreboard bench for single_clock_packet_fifo
// (WIDTH=16, DEPTH=16, OUT_REG=1).
module tb_single_clock_packet_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_commit, wr_rollback;
  logic [15:0] wr_data;
  logic [4:0]  wr_size, rd_size;
  logic        wr_full, wr_overflow;
  logic        rd_en, rd_commit, rd_rollback;
  logic [15:0] rd_data;
  logic        rd_valid, rd_empty, rd_underflow;

  single_clock_packet_fifo #(
    .WIDTH(16), .DEPTH(16), .USE_BLOCK(1), .OUT_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_rollback(wr_rollback),
    .wr_size(wr_size), .wr_full(wr_full),
    .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_size(rd_size), .rd_empty(rd_empty),
    .rd_underflow(rd_underflow),
    .rd_commit(rd_commit), .rd_rollback(rd_rollback)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl[$];
  logic [15:0] pend[$];
  logic [15:0] held[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_valid", 32'(rd_valid), 1);
        check("rd_data", 32'(rd_data), 32'(e.data));
      end else if (rd_valid) begin
        check("rd_valid_extra", 32'(rd_valid), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_model();
    while (pend.size() != 0) mdl.push_back(pend.pop_front());
  endtask

  task automatic wr(input logic [15:0] d, input bit c);
    wr_en = 1'b1; wr_data = d; wr_commit = c;
    step();
    wr_en = 1'b0; wr_commit = 1'b0;
    pend.push_back(d);
    if (c) commit_model();
  endtask

  task automatic pop_issue();
    exp_t e;
    rd_en  = 1'b1;
    e.data = mdl.pop_front();
    e.due  = cyc + 2;
    exp_q.push_back(e);
    held.push_back(e.data);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) begin
      pop_issue();
      step();
    end
    rd_en = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic rd_release();
    rd_commit = 1'b1;
    step();
    rd_commit = 1'b0;
    held.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_size"}, 32'(wr_size), 16);
    check({tag, "_wr_full"}, 32'(wr_full), 0);
    check({tag, "_wr_ovf"}, 32'(wr_overflow), 0);
    check({tag, "_rd_size"}, 32'(rd_size), 0);
    check({tag, "_rd_empty"}, 32'(rd_empty), 1);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_udf"}, 32'(rd_underflow), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0;
    wr_commit = 1'b0; wr_rollback = 1'b0;
    rd_en = 1'b0; rd_commit = 1'b0; rd_rollback = 1'b0;
    repeat (3) step();
    check_reset("rst");
    reset = 1'b0;
    step();

    // basic frame, commit visibility lag, 2-cycle pops
    for (int i = 1; i <= 5; i++) wr(16'(i), 1'b0);
    check("s1_wr_size_pend", 32'(wr_size), 11);
    wr_commit = 1'b1; step(); wr_commit = 1'b0;
    commit_model();
    check("s1_empty_lag", 32'(rd_empty), 1);
    step();
    check("s1_empty", 32'(rd_empty), 0);
    check("s1_rd_size", 32'(rd_size), 5);
    pops(5);
    check("s1_rd_size_end", 32'(rd_size), 0);
    drain();
    rd_release();
    step();
    check("s1_wr_size", 32'(wr_size), 16);

    // rollback beats same-cycle write and commit
    for (int i = 0; i < 3; i++) wr(16'h0100 + 16'(i), 1'b0);
    wr_rollback = 1'b1; wr_en = 1'b1;
    wr_data = 16'hBEEF; wr_commit = 1'b1;
    step();
    wr_rollback = 1'b0; wr_en = 1'b0; wr_commit = 1'b0;
    pend.delete();
    check("s2_wr_size_rb", 32'(wr_size), 16);
    wr(16'hAAAA, 1'b1);
    step();
    check("s2_rd_size", 32'(rd_size), 1);
    pops(1);
    drain();
    rd_release();
    step();

    // fill uncommitted, overflow pulse, rollback
    for (int i = 0; i < 16; i++) wr(16'h0200 + 16'(i), 1'b0);
    check("s3_full", 32'(wr_full), 1);
    check("s3_wr_size", 32'(wr_size), 0);
    wr_en = 1'b1; wr_data = 16'hDEAD;
    step();
    wr_en = 1'b0;
    check("s3_ovf", 32'(wr_overflow), 1);
    step();
    check("s3_ovf_pulse", 32'(wr_overflow), 0);
    wr_rollback = 1'b1; step(); wr_rollback = 1'b0;
    pend.delete();
    check("s3_wr_size_rb", 32'(wr_size), 16);
    check("s3_full_clr", 32'(wr_full), 0);
    check("s3_rd_size", 32'(rd_size), 0);

    // pop while empty
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("s4_udf", 32'(rd_underflow), 1);
    check("s4_valid", 32'(rd_valid), 0);
    step();
    check("s4_udf_pulse", 32'(rd_underflow), 0);
    check("s4_rd_size", 32'(rd_size), 0);
    check("s4_empty", 32'(rd_empty), 1);
    check("s4_wr_size", 32'(wr_size), 16);
    step();

`ifdef PACKET_FIFO_RD_ROLLBACK_EN
    // re-read after read rollback; space freed on commit
    for (int i = 0; i < 4; i++)
      wr(16'h0300 + 16'(i), i == 3);
    step();
    pops(4);
    drain();
    check("s5_wr_size_hold", 32'(wr_size), 12);
    rd_rollback = 1'b1; rd_en = 1'b1;
    step();
    rd_rollback = 1'b0; rd_en = 1'b0;
    while (held.size() != 0) mdl.push_front(held.pop_back());
    check("s5_rd_size_rb", 32'(rd_size), 4);
    pops(4);
    drain();
    check("s5_wr_size_hold2", 32'(wr_size), 12);
    rd_release();
    check("s5_wr_size_lag", 32'(wr_size), 12);
    step();
    check("s5_wr_size_free", 32'(wr_size), 16);
`else
    // read commit/rollback are inert in this build
    wr(16'h0300, 1'b0);
    wr(16'h0301, 1'b1);
    step();
    pops(2);
    rd_rollback = 1'b1; step(); rd_rollback = 1'b0;
    step();
    check("s5_rd_size_norb", 32'(rd_size), 0);
    check("s5_wr_size", 32'(wr_size), 16);
    drain();
`endif

    // simultaneous write+commit and pop every cycle
    wr(16'h0400, 1'b0);
    wr(16'h0401, 1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h0410 + 16'(i);
      wr_commit = 1'b1;
      pop_issue();
      step();
      pend.push_back(wr_data);
      commit_model();
    end
    wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0;
    step();
    check("s7_rd_size", 32'(rd_size), 2);
    pops(2);
    drain();
    rd_release();
    step();

    // reset mid-frame discards committed and pending
    for (int i = 0; i < 6; i++)
      wr(16'h0500 + 16'(i), i == 5);
    wr(16'h0510, 1'b0);
    wr(16'h0511, 1'b0);
    reset = 1'b1;
    step();
    check_reset("s6");
    reset = 1'b0;
    mdl.delete(); pend.delete(); held.delete();
    step();
    wr(16'h0600, 1'b1);
    step();
    check("s6_rd_size", 32'(rd_size), 1);
    pops(1);
    drain();

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
